// File: rtl/alu_exec.sv
// Iterative ALU execute stage: single-cycle logic/arith ops, one-bit-per-cycle shifts.
// Define ALU_EXEC_OVF_EN to build signed-overflow detection for add/sub.
module alu_exec (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [3:0]  alu_op,
    input  logic        shift,
    input  logic [4:0]  shamt,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        ovf,
    output logic        busy
);

    localparam logic [3:0] OpAdd  = 4'b1110;
    localparam logic [3:0] OpSub  = 4'b0100;
    localparam logic [3:0] OpAnd  = 4'b0010;
    localparam logic [3:0] OpOr   = 4'b0011;
    localparam logic [3:0] OpXor  = 4'b0111;
    localparam logic [3:0] OpSll  = 4'b1010;
    localparam logic [3:0] OpSrl  = 4'b1000;
    localparam logic [3:0] OpSra  = 4'b1001;
    localparam logic [3:0] OpPass = 4'b1100;

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] result_q, result_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [1:0]  kind_q, kind_d;
    logic [31:0] sum, diff, alu_res;
    logic        is_shift, accept;

    // The shift flag is redundant with alu_op: shift class is decided by the code alone.
    logic unused_shift;
    assign unused_shift = shift;

    assign sum      = a + b;
    assign diff     = a - b;
    assign is_shift = (alu_op == OpSll) || (alu_op == OpSrl) || (alu_op == OpSra);
    assign accept   = in_valid && (state_q == StIdle);

    always_comb begin
        alu_res = 32'h0;
        case (alu_op)
            OpAdd:   alu_res = sum;
            OpSub:   alu_res = diff;
            OpAnd:   alu_res = a & b;
            OpOr:    alu_res = a | b;
            OpXor:   alu_res = a ^ b;
            OpPass:  alu_res = a;
            default: alu_res = 32'h0;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        cnt_d    = cnt_q;
        kind_d   = kind_q;
        case (state_q)
            StIdle: begin
                if (in_valid) begin
                    if (is_shift) begin
                        result_d = b;
                        cnt_d    = shamt;
                        kind_d   = alu_op[1:0];
                        state_d  = (shamt == 5'd0) ? StDone : StShift;
                    end else begin
                        result_d = alu_res;
                        state_d  = StDone;
                    end
                end
            end
            StShift: begin
                // kind_q: 2'b10 sll, 2'b01 sra, 2'b00 srl
                case (kind_q)
                    2'b10:   result_d = {result_q[30:0], 1'b0};
                    2'b01:   result_d = {result_q[31], result_q[31:1]};
                    default: result_d = {1'b0, result_q[31:1]};
                endcase
                cnt_d = cnt_q - 5'd1;
                if (cnt_q == 5'd1) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= 32'h0;
            cnt_q    <= 5'd0;
            kind_q   <= 2'b00;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            cnt_q    <= cnt_d;
            kind_q   <= kind_d;
        end
    end

`ifdef ALU_EXEC_OVF_EN
    logic ovf_q, ovf_d;
    logic add_ovf, sub_ovf;

    assign add_ovf = (a[31] == b[31]) && (sum[31] != a[31]);
    assign sub_ovf = (a[31] != b[31]) && (diff[31] != a[31]);

    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = (alu_op == OpAdd) ? add_ovf :
                    (alu_op == OpSub) ? sub_ovf : 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf = (state_q == StDone) && ovf_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
    assign ovf           = 1'b0;
`endif

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StShift);
    assign result    = result_q;
    assign zero      = (state_q == StDone) && (result_q == 32'h0);

endmodule

// File: tb/tb_alu_exec.sv
// Scoreboard bench for alu_exec: stimulus pushes expected responses, a monitor pops and compares.
module tb_alu_exec;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  alu_op;
    logic        shift;
    logic [4:0]  shamt;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic        busy;

`ifdef ALU_EXEC_OVF_EN
    localparam logic OVF = 1'b1;
`else
    localparam logic OVF = 1'b0;
`endif

    alu_exec dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .shift     (shift),
        .shamt     (shamt),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic        z;
        logic        o;
        int          acc;
        int          lat;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   seen = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL spurious_result got=%h exp=none (cycle %0d)", result, cyc);
            end else begin
                if (!seen) begin
                    seen = 1'b1;
                    chk("latency", 32'(cyc - sbq[0].acc), 32'(sbq[0].lat));
                end
                chk("result", result, sbq[0].res);
                if (out_ready) begin
                    chk("zero", {31'b0, zero}, {31'b0, sbq[0].z});
                    chk("ovf", {31'b0, ovf}, {31'b0, sbq[0].o});
                    void'(sbq.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic sh, input logic [4:0] amt,
                         input logic [31:0] va, input logic [31:0] vb, input bit push,
                         input logic [31:0] eres, input logic ez, input logic eo,
                         input int elat);
        exp_t e;
        int   n = 0;
        while (!in_ready && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("accept_timeout", {31'b0, in_ready}, 32'd1);
        alu_op   = op;
        shift    = sh;
        shamt    = amt;
        a        = va;
        b        = vb;
        in_valid = 1'b1;
        if (push) begin
            e.res = eres;
            e.z   = ez;
            e.o   = eo;
            e.acc = cyc;
            e.lat = elat;
            sbq.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 32'hDEAD_BEEF;
        b        = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        int n = 0;
        while ((sbq.size() != 0 || !in_ready) && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_timeout", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int bcnt;
        int n;
        rst_n = 1'b0; in_valid = 1'b0; alu_op = 4'h0; shift = 1'b0; shamt = 5'd0;
        a = 32'h0; b = 32'h0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_result", result, 32'h0);
        chk("rst_zero", {31'b0, zero}, 32'd0);
        chk("rst_ovf", {31'b0, ovf}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);

        // Back-to-back single-cycle ops.
        issue(4'b1110, 1'b0, 5'd0, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1'b0, OVF, 1);
        issue(4'b0100, 1'b0, 5'd0, 32'h5, 32'h5, 1, 32'h0, 1'b1, 1'b0, 1);
        issue(4'b0100, 1'b0, 5'd0, 32'h8000_0000, 32'h1, 1, 32'h7FFF_FFFF, 1'b0, OVF, 1);
        issue(4'b0010, 1'b0, 5'd0, 32'h0000_F0F0, 32'h0000_FF00, 1, 32'h0000_F000, 1'b0, 1'b0, 1);
        issue(4'b0011, 1'b0, 5'd0, 32'h0000_F0F0, 32'h0F00_FF00, 1, 32'h0F00_FFF0, 1'b0, 1'b0, 1);
        issue(4'b0111, 1'b0, 5'd0, 32'hFFFF_0000, 32'hF0F0_F0F0, 1, 32'h0F0F_F0F0, 1'b0, 1'b0, 1);
        issue(4'b1100, 1'b0, 5'd0, 32'h0000_1234, 32'h9, 1, 32'h0000_1234, 1'b0, 1'b0, 1);
        issue(4'b0000, 1'b0, 5'd0, 32'h3, 32'h4, 1, 32'h0, 1'b1, 1'b0, 1);
        issue(4'b1110, 1'b1, 5'd7, 32'h2, 32'h3, 1, 32'h5, 1'b0, 1'b0, 1);
        issue(4'b1010, 1'b1, 5'd0, 32'hFFFF, 32'h1, 1, 32'h1, 1'b0, 1'b0, 1);
        issue(4'b1010, 1'b0, 5'd2, 32'hFFFF, 32'h3, 1, 32'hC, 1'b0, 1'b0, 3);
        drain();

        // Longest arithmetic shift; count cycles spent busy.
        issue(4'b1001, 1'b1, 5'd31, 32'h0, 32'h8000_0000, 1, 32'hFFFF_FFFF, 1'b0, 1'b0, 32);
        bcnt = 0;
        n = 0;
        while (!out_valid && n < 40) begin
            if (busy) bcnt++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("sra_busy_cycles", 32'(bcnt), 32'd31);
        drain();

        // Held result under backpressure.
        out_ready = 1'b0;
        issue(4'b1000, 1'b1, 5'd4, 32'h0, 32'hF000_0000, 1, 32'h0F00_0000, 1'b0, 1'b0, 5);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_in_ready", {31'b0, in_ready}, 32'd0);
            chk("hold_out_valid", {31'b0, out_valid}, 32'd1);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("release_out_valid", {31'b0, out_valid}, 32'd0);
        chk("release_in_ready", {31'b0, in_ready}, 32'd1);
        drain();

        // Reset in the middle of a shift abandons it.
        issue(4'b1010, 1'b1, 5'd20, 32'h0, 32'h1, 0, 32'h0, 1'b0, 1'b0, 0);
        repeat (9) begin
            @(posedge clk);
            #1;
        end
        chk("pre_rst_busy", {31'b0, busy}, 32'd1);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_busy", {31'b0, busy}, 32'd0);
        chk("midrst_result", result, 32'h0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        rst_n = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
        end
        chk("post_rst_idle", {31'b0, in_ready}, 32'd1);

        // A new op after the abandoned one still works.
        issue(4'b1110, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b1, 1'b0, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
